pulse_width_meter: RTL and testbench



---
 rtl/pulse_width_meter_pkg.sv | 19 +
 rtl/pwm_edge_detect.sv | 36 +++
 rtl/pulse_width_meter.sv | 144 ++++++++++++++
 tb/tb_pulse_width_meter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_width_meter_pkg.sv
// Shared types for the pulse width meter: FSM state encoding and the result beat layout.
package pulse_width_meter_pkg;

    localparam int PWM_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        MEAS_HIGH,
        MEAS_LOW
    } pwm_state_t;

    typedef struct packed {
        logic [PWM_CNT_W-1:0] high;
        logic [PWM_CNT_W-1:0] low;
        logic                 sat;
        logic                 err;
    } pwm_result_t;

endpackage

// File: rtl/pwm_edge_detect.sv
// Samples the measured signal and flags its rising/falling edges.
// Defining PULSE_WIDTH_METER_SYNC_EN inserts a 2-flop synchronizer ahead of the edge detector.
module pwm_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic sig_in,
    output logic sig_s,
    output logic rise,
    output logic fall
);

`ifdef PULSE_WIDTH_METER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[0], sig_in};
    end

    assign sig_s = sync_q[1];
`else
    assign sig_s = sig_in;
`endif

    logic sig_d;

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) sig_d <= 1'b0;
        else       sig_d <= sig_s;
    end

    assign rise = sig_s & ~sig_d;
    assign fall = ~sig_s & sig_d;

endmodule

// File: rtl/pulse_width_meter.sv
// Measures high/low phase widths of sig_in and reports one result per period on valid/ready.
// Optional input synchronizer: define PULSE_WIDTH_METER_SYNC_EN.
module pulse_width_meter
    import pulse_width_meter_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int EXP_HIGH = 6,
    parameter int EXP_LOW  = 4,
    parameter int TOL      = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sig_in,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] high_count,
    output logic [CNT_W-1:0] low_count,
    output logic             meas_err,
    output logic             meas_sat,
    output logic             overflow,
    output logic             stuck
);

    localparam logic [CNT_W-1:0]        CNT_MAX = '1;
    localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);
    localparam logic signed [CNT_W:0]   EXP_H_S = (CNT_W+1)'(EXP_HIGH);
    localparam logic signed [CNT_W:0]   EXP_L_S = (CNT_W+1)'(EXP_LOW);
    localparam logic signed [CNT_W:0]   TOL_S   = (CNT_W+1)'(TOL);

    // Same layout as pwm_result_t, sized by this instance's CNT_W.
    typedef struct packed {
        logic [CNT_W-1:0] high;
        logic [CNT_W-1:0] low;
        logic             sat;
        logic             err;
    } result_t;

    logic sig_s;
    logic rise;
    logic fall;

    pwm_edge_detect u_edge (
        .clock  (clock),
        .reset  (reset),
        .sig_in (sig_in),
        .sig_s  (sig_s),
        .rise   (rise),
        .fall   (fall)
    );

    pwm_state_t       state, state_next;
    logic [CNT_W-1:0] hi_cnt, hi_next;
    logic [CNT_W-1:0] lo_cnt, lo_next;
    logic             emit;
    result_t          res_q, res_new;

    function automatic logic off_tol(input logic [CNT_W-1:0] value,
                                     input logic signed [CNT_W:0] expected);
        logic signed [CNT_W:0] diff;
        diff = $signed({1'b0, value}) - expected;
        if (diff < 0) diff = -diff;
        return diff > TOL_S;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            hi_cnt <= '0;
            lo_cnt <= '0;
        end else begin
            state  <= state_next;
            hi_cnt <= hi_next;
            lo_cnt <= lo_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        hi_next    = hi_cnt;
        lo_next    = lo_cnt;
        emit       = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_next = MEAS_HIGH;
                    hi_next    = CNT_ONE;
                end
            end
            MEAS_HIGH: begin
                if (fall) begin
                    state_next = MEAS_LOW;
                    lo_next    = CNT_ONE;
                end else if (hi_cnt != CNT_MAX) begin
                    hi_next = hi_cnt + CNT_ONE;
                end
            end
            MEAS_LOW: begin
                if (rise) begin
                    emit       = 1'b1;
                    state_next = MEAS_HIGH;
                    hi_next    = CNT_ONE;
                    lo_next    = '0;
                end else if (lo_cnt != CNT_MAX) begin
                    lo_next = lo_cnt + CNT_ONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        res_new.high = hi_cnt;
        res_new.low  = lo_cnt;
        res_new.sat  = (hi_cnt == CNT_MAX) || (lo_cnt == CNT_MAX);
        res_new.err  = off_tol(hi_cnt, EXP_H_S) || off_tol(lo_cnt, EXP_L_S);
    end

    // A pending, unaccepted beat wins over a new one; the newcomer is dropped and flagged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meas_valid <= 1'b0;
            res_q      <= '0;
            overflow   <= 1'b0;
        end else if (emit) begin
            if (!meas_valid || meas_ready) begin
                res_q      <= res_new;
                meas_valid <= 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end else if (meas_valid && meas_ready) begin
            meas_valid <= 1'b0;
        end
    end

    assign high_count = res_q.high;
    assign low_count  = res_q.low;
    assign meas_sat   = res_q.sat;
    assign meas_err   = res_q.err;
    assign stuck      = ((state == MEAS_HIGH) && (hi_cnt == CNT_MAX)) ||
                        ((state == MEAS_LOW)  && (lo_cnt == CNT_MAX));

endmodule

// File: tb/tb_pulse_width_meter.sv
// Self-checking bench: table vectors, directed corner sequences, and random periods vs a run-length model.
module tb_pulse_width_meter;
    import pulse_width_meter_pkg::*;

    localparam int W     = PWM_CNT_W;
    localparam int MAXV  = (1 << W) - 1;
    localparam int EXP_H = 6;
    localparam int EXP_L = 4;
`ifdef PULSE_WIDTH_METER_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif

    logic clock = 1'b0;
    logic reset;
    logic sig_in;
    logic meas_ready;
    always #5 clock = ~clock;

    logic         d_valid, d_err, d_sat, d_ovf, d_stuck;
    logic [W-1:0] d_high, d_low;
    logic         t_valid, t_err, t_sat, t_ovf, t_stuck;
    logic [W-1:0] t_high, t_low;
    logic         s_valid, s_err, s_sat, s_ovf, s_stuck;
    logic [3:0]   s_high, s_low;

    pulse_width_meter #(.CNT_W(W), .EXP_HIGH(EXP_H), .EXP_LOW(EXP_L), .TOL(0)) u_dut (
        .clock(clock), .reset(reset), .sig_in(sig_in), .meas_valid(d_valid),
        .meas_ready(meas_ready), .high_count(d_high), .low_count(d_low), .meas_err(d_err),
        .meas_sat(d_sat), .overflow(d_ovf), .stuck(d_stuck));

    pulse_width_meter #(.CNT_W(W), .EXP_HIGH(EXP_H), .EXP_LOW(EXP_L), .TOL(1)) u_tol (
        .clock(clock), .reset(reset), .sig_in(sig_in), .meas_valid(t_valid),
        .meas_ready(meas_ready), .high_count(t_high), .low_count(t_low), .meas_err(t_err),
        .meas_sat(t_sat), .overflow(t_ovf), .stuck(t_stuck));

    pulse_width_meter #(.CNT_W(4), .EXP_HIGH(EXP_H), .EXP_LOW(EXP_L), .TOL(0)) u_sat (
        .clock(clock), .reset(reset), .sig_in(sig_in), .meas_valid(s_valid),
        .meas_ready(meas_ready), .high_count(s_high), .low_count(s_low), .meas_err(s_err),
        .meas_sat(s_sat), .overflow(s_ovf), .stuck(s_stuck));

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model for u_dut: tracks run lengths of the sampled signal and the one-deep output slot.
    logic [1:0]  m_pipe;
    bit          m_prev, m_started, m_in_low, m_valid, m_ovf;
    int          m_hi, m_lo;
    pwm_result_t m_res;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic pwm_result_t make_result(input int h, input int l);
        pwm_result_t r;
        int hs, ls;
        hs = (h > MAXV) ? MAXV : h;
        ls = (l > MAXV) ? MAXV : l;
        r.high = W'(hs);
        r.low  = W'(ls);
        r.sat  = (hs == MAXV) || (ls == MAXV);
        r.err  = (iabs(hs - EXP_H) > 0) || (iabs(ls - EXP_L) > 0);
        return r;
    endfunction

    task automatic model_reset();
        m_pipe = '0; m_prev = 0; m_started = 0; m_in_low = 0;
        m_valid = 0; m_ovf = 0; m_hi = 0; m_lo = 0; m_res = '0;
    endtask

    task automatic model_step(input bit s_in, input bit rdy);
        bit s, emit;
        pwm_result_t nr;
        if (D == 0) begin
            s = s_in;
        end else begin
            s = m_pipe[1];
            m_pipe = {m_pipe[0], s_in};
        end
        emit = 0;
        nr = '0;
        if (s && !m_prev) begin
            if (m_started && m_in_low) begin
                emit = 1;
                nr = make_result(m_hi, m_lo);
            end
            m_started = 1; m_in_low = 0; m_hi = 1; m_lo = 0;
        end else if (m_started) begin
            if (s) m_hi++;
            else if (!m_in_low) begin m_in_low = 1; m_lo = 1; end
            else m_lo++;
        end
        m_prev = s;
        if (emit) begin
            if (!m_valid || rdy) begin m_res = nr; m_valid = 1; end
            else m_ovf = 1;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic check_model();
        bit m_stuck;
        m_stuck = m_started && (m_in_low ? (m_lo >= MAXV) : (m_hi >= MAXV));
        check("rnd_valid", 32'(d_valid), 32'(m_valid));
        check("rnd_overflow", 32'(d_ovf), 32'(m_ovf));
        check("rnd_stuck", 32'(d_stuck), 32'(m_stuck));
        if (m_valid) begin
            check("rnd_high", 32'(d_high), 32'(m_res.high));
            check("rnd_low", 32'(d_low), 32'(m_res.low));
            check("rnd_sat", 32'(d_sat), 32'(m_res.sat));
            check("rnd_err", 32'(d_err), 32'(m_res.err));
        end
    endtask

    // Drive at the falling edge, let the rising edge sample, check at the next falling edge.
    task automatic tick(input bit s, input bit r);
        sig_in = s;
        meas_ready = r;
        @(posedge clock);
        model_step(s, r);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sig_in = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic check_res(input string tag, input pwm_result_t e);
        check({tag, "_valid"}, 32'(d_valid), 32'd1);
        check({tag, "_high"}, 32'(d_high), 32'(e.high));
        check({tag, "_low"}, 32'(d_low), 32'(e.low));
        check({tag, "_sat"}, 32'(d_sat), 32'(e.sat));
        check({tag, "_err"}, 32'(d_err), 32'(e.err));
    endtask

    typedef struct {
        int          h;
        int          l;
        pwm_result_t exp;
    } vec_t;

    function automatic vec_t mk(input int h, input int l, input int eh, input int el, input bit err);
        vec_t v;
        v.h = h; v.l = l;
        v.exp.high = W'(eh); v.exp.low = W'(el); v.exp.sat = 1'b0; v.exp.err = err;
        return v;
    endfunction

    vec_t tbl[7];

    initial begin
        tbl[0] = mk(6, 4, 6, 4, 0);
        tbl[1] = mk(6, 4, 6, 4, 0);
        tbl[2] = mk(7, 4, 7, 4, 1);
        tbl[3] = mk(6, 5, 6, 5, 1);
        tbl[4] = mk(3, 1, 3, 1, 1);
        tbl[5] = mk(12, 2, 12, 2, 1);
        tbl[6] = mk(6, 4, 6, 4, 0);

        sig_in = 1'b0;
        meas_ready = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clock);
        check("rst_valid", 32'(d_valid), 32'd0);
        check("rst_high", 32'(d_high), 32'd0);
        check("rst_low", 32'(d_low), 32'd0);
        check("rst_err", 32'(d_err), 32'd0);
        check("rst_sat", 32'(d_sat), 32'd0);
        check("rst_overflow", 32'(d_ovf), 32'd0);
        check("rst_stuck", 32'(d_stuck), 32'd0);
        reset = 1'b0;

        // Table vectors, consumer always ready; the leading low stretch is a discarded partial phase.
        repeat (3) tick(0, 1);
        for (int i = 0; i < 7; i++) begin
            tick(1, 1);
            repeat (D) tick(1, 1);
            if (i == 0) check("tbl_first_no_emit", 32'(d_valid), 32'd0);
            else        check_res($sformatf("tbl%0d", i - 1), tbl[i-1].exp);
            repeat (tbl[i].h - 1 - D) tick(1, 1);
            repeat (tbl[i].l) tick(0, 1);
        end
        tick(1, 1);
        repeat (D) tick(1, 1);
        check_res("tbl6", tbl[6].exp);
        tick(1, 1);
        check("tbl_drain", 32'(d_valid), 32'd0);

        // Tolerance of one cycle: 8 is out, 7 is in.
        do_reset();
        repeat (2) tick(0, 1);
        repeat (8) tick(1, 1);
        repeat (4) tick(0, 1);
        tick(1, 1);
        repeat (D) tick(1, 1);
        check("tol8_valid", 32'(t_valid), 32'd1);
        check("tol8_high", 32'(t_high), 32'd8);
        check("tol8_err", 32'(t_err), 32'd1);
        repeat (7 - 1 - D) tick(1, 1);
        repeat (4) tick(0, 1);
        tick(1, 1);
        repeat (D) tick(1, 1);
        check("tol7_high", 32'(t_high), 32'd7);
        check("tol7_err", 32'(t_err), 32'd0);
        check("tol0_err7", 32'(d_err), 32'd1);

        // Back-pressure: second result is dropped, first is held, overflow sticks.
        do_reset();
        repeat (2) tick(0, 0);
        repeat (6) tick(1, 0);
        repeat (4) tick(0, 0);
        tick(1, 0);
        repeat (D) tick(1, 0);
        check("ovf_first_high", 32'(d_high), 32'd6);
        check("ovf_not_yet", 32'(d_ovf), 32'd0);
        repeat (5 - 1 - D) tick(1, 0);
        repeat (5) tick(0, 0);
        tick(1, 0);
        repeat (D) tick(1, 0);
        check("ovf_held_valid", 32'(d_valid), 32'd1);
        check("ovf_held_high", 32'(d_high), 32'd6);
        check("ovf_held_low", 32'(d_low), 32'd4);
        check("ovf_flag", 32'(d_ovf), 32'd1);
        tick(1, 1);
        check("ovf_transfer", 32'(d_valid), 32'd0);
        repeat (3) begin
            tick(1, 1);
            check("ovf_no_second_beat", 32'(d_valid), 32'd0);
            check("ovf_sticky", 32'(d_ovf), 32'd1);
        end

        // 4-bit counters: high held 20 cycles saturates at 15.
        do_reset();
        repeat (2) tick(0, 1);
        for (int k = 1; k <= 20; k++) begin
            tick(1, 1);
            check($sformatf("sat_stuck_h%0d", k), 32'(s_stuck), 32'(k >= 15 + D));
        end
        for (int k = 1; k <= 3; k++) begin
            tick(0, 1);
            check($sformatf("sat_stuck_l%0d", k), 32'(s_stuck), 32'(k <= D));
        end
        tick(1, 1);
        repeat (D) tick(1, 1);
        check("sat_valid", 32'(s_valid), 32'd1);
        check("sat_high", 32'(s_high), 32'd15);
        check("sat_low", 32'(s_low), 32'd3);
        check("sat_flag", 32'(s_sat), 32'd1);
        check("sat_err", 32'(s_err), 32'd1);
        check("wide_high", 32'(d_high), 32'd20);
        check("wide_sat", 32'(d_sat), 32'd0);

        // Async reset three cycles into the low phase with a result pending.
        do_reset();
        repeat (2) tick(0, 0);
        repeat (6) tick(1, 0);
        repeat (4) tick(0, 0);
        repeat (6) tick(1, 0);
        repeat (3 + D) tick(0, 0);
        check("arst_pre_valid", 32'(d_valid), 32'd1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("arst_valid", 32'(d_valid), 32'd0);
        check("arst_high", 32'(d_high), 32'd0);
        check("arst_low", 32'(d_low), 32'd0);
        check("arst_err", 32'(d_err), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        tick(0, 1);
        tick(1, 1);
        repeat (D) tick(1, 1);
        check("arst_no_emit", 32'(d_valid), 32'd0);
        repeat (6 - 1 - D) tick(1, 1);
        repeat (4) tick(0, 1);
        tick(1, 1);
        repeat (D) tick(1, 1);
        check_res("arst_fresh", tbl[0].exp);

        // Random periods and back-pressure against the reference model.
        do_reset();
        for (int p = 0; p < 80; p++) begin
            int h, l;
            h = $urandom_range(1, 9);
            l = $urandom_range(1, 7);
            repeat (h) begin
                tick(1, $urandom_range(0, 3) != 0);
                check_model();
            end
            repeat (l) begin
                tick(0, $urandom_range(0, 3) != 0);
                check_model();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
